// File: rtl/axis_daq_pkg.sv
// Shared state encoding, control-word bit map and delimiter word
// for the axis_daq_mc capture engine.
package axis_daq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRETRIG,
        ST_WAIT_TRIG,
        ST_POST,
        ST_DONE
    } daq_state_e;

    localparam int CTL_ENABLE   = 0;
    localparam int CTL_FORCE    = 1;
    localparam int CTL_EDGE     = 2;
    localparam int CTL_SLOPE    = 3;
    localparam int CTL_CHSEL_LO = 4;
    localparam int CTL_CHSEL_HI = 7;
    localparam int CTL_THR_LO   = 16;
    localparam int CTL_THR_HI   = 31;

    // Max-positive, MSB-aligned: take the top SAMPLE_WIDTH bits.
    localparam logic [31:0] DAQ_DELIM = 32'h7FFF_FFFF;

endpackage

// File: rtl/daq_trigger.sv
// Threshold comparator with optional edge qualification against
// the previous valid sample seen since arming.
module daq_trigger #(
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           smp_vld,
    input  logic signed [SAMPLE_WIDTH-1:0] smp,
    input  logic signed [SAMPLE_WIDTH-1:0] thr,
    input  logic                           edge_mode,
    input  logic                           slope,
    output logic                           hit
);
    logic pass;
    logic prev_vld_q, prev_vld_d;
    logic prev_pass_q, prev_pass_d;

    assign pass = slope ? (smp <= thr) : (smp >= thr);

    always_comb begin
        prev_vld_d  = prev_vld_q;
        prev_pass_d = prev_pass_q;
        if (clr) begin
            prev_vld_d  = 1'b0;
            prev_pass_d = 1'b0;
        end else if (smp_vld) begin
            prev_vld_d  = 1'b1;
            prev_pass_d = pass;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_vld_q  <= 1'b0;
            prev_pass_q <= 1'b0;
        end else begin
            prev_vld_q  <= prev_vld_d;
            prev_pass_q <= prev_pass_d;
        end
    end

    assign hit = smp_vld && pass &&
                 (!edge_mode || (prev_vld_q && !prev_pass_q));

endmodule

// File: rtl/axis_daq_mc.sv
// Multi-channel AXI-Stream DAQ: circular pre/post-trigger capture to BRAM.
// Define DAQ_DELIMITER_EN to mark the final post-trigger word as max-positive.
module axis_daq_mc
    import axis_daq_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int SAMPLE_WIDTH     = 16,
    parameter int NUM_CH           = 2,
    parameter int BRAM_ADDR_WIDTH  = 14
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [31:0]                 daq_control,
    input  logic [15:0]                 daq_pretrigger,
    output logic [31:0]                 daq_status,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        bram_porta_clk,
    output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
    output logic [SAMPLE_WIDTH-1:0]     bram_porta_wrdata,
    output logic                        bram_porta_we
);
    localparam int AW    = BRAM_ADDR_WIDTH;
    localparam int SW    = SAMPLE_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam logic [16:0] PRE_MAX = 17'(DEPTH - 1);
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    daq_state_e st_q, st_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] pre_q, pre_d;
    logic [AW-1:0] taddr_q, taddr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          edge_q, edge_d;
    logic          slope_q, slope_d;
    logic [3:0]    chsel_q, chsel_d;
    logic signed [SW-1:0] thr_q, thr_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [SW-1:0] wd_q, wd_d;
    logic          we_q, we_d;

    logic          ena, frc, hit, armed, trig_clr, trig_vld;
    logic          wr, wr_last;
    logic [AW:0]   cnt_inc, post_len;
    logic [AW-1:0] pre_in;
    logic signed [15:0]   thr_raw;
    logic signed [SW-1:0] thr_in;
    logic [SW-1:0] smp, last_wd;
    logic          unused_ctl;

    assign ena        = daq_control[CTL_ENABLE];
    assign frc        = daq_control[CTL_FORCE];
    assign thr_raw    = daq_control[CTL_THR_HI:CTL_THR_LO];
    assign thr_in     = SW'(thr_raw);
    assign unused_ctl = ^daq_control[15:8];
    assign pre_in     = ({1'b0, daq_pretrigger} > PRE_MAX) ? '1
                                                          : daq_pretrigger[AW-1:0];
    assign post_len   = DEPTH_W - {1'b0, pre_q};

    // Out-of-range channel selects fall back to CH0.
    always_comb begin
        smp = s_axis_tdata[SW-1:0];
        for (int i = 1; i < NUM_CH; i++) begin
            if (chsel_q == 4'(i)) smp = s_axis_tdata[i*SW +: SW];
        end
    end

`ifdef DAQ_DELIMITER_EN
    assign last_wd = DAQ_DELIM[31 -: SW];
`else
    assign last_wd = smp;
`endif

    assign armed    = (st_q == ST_PRETRIG) || (st_q == ST_WAIT_TRIG);
    assign trig_clr = (st_q == ST_IDLE);
    assign trig_vld = s_axis_tvalid && armed;

    daq_trigger #(
        .SAMPLE_WIDTH(SW)
    ) u_trig (
        .clk      (aclk),
        .rst      (areset),
        .clr      (trig_clr),
        .smp_vld  (trig_vld),
        .smp      (smp),
        .thr      (thr_q),
        .edge_mode(edge_q),
        .slope    (slope_q),
        .hit      (hit)
    );

    always_comb begin
        st_d    = st_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        taddr_d = taddr_q;
        pre_d   = pre_q;
        edge_d  = edge_q;
        slope_d = slope_q;
        chsel_d = chsel_q;
        thr_d   = thr_q;
        wr      = 1'b0;
        wr_last = 1'b0;
        cnt_inc = cnt_q + 1'b1;
        unique case (st_q)
            ST_IDLE: begin
                if (ena) begin
                    st_d    = ST_PRETRIG;
                    addr_d  = '0;
                    cnt_d   = '0;
                    taddr_d = '0;
                    pre_d   = pre_in;
                    edge_d  = daq_control[CTL_EDGE];
                    slope_d = daq_control[CTL_SLOPE];
                    chsel_d = daq_control[CTL_CHSEL_HI:CTL_CHSEL_LO];
                    thr_d   = thr_in;
                end
            end
            ST_PRETRIG: begin
                if (!ena) begin
                    st_d = ST_IDLE;
                end else if (pre_q == '0) begin
                    st_d = ST_WAIT_TRIG;
                end else if (s_axis_tvalid) begin
                    wr    = 1'b1;
                    cnt_d = cnt_inc;
                    if (cnt_inc == {1'b0, pre_q}) st_d = ST_WAIT_TRIG;
                end
            end
            ST_WAIT_TRIG: begin
                if (!ena) begin
                    st_d = ST_IDLE;
                end else begin
                    wr = s_axis_tvalid;
                    // A forced trigger on an idle beat counts from the next beat.
                    if (frc || hit) begin
                        st_d    = ST_POST;
                        taddr_d = addr_q;
                        cnt_d   = {{AW{1'b0}}, s_axis_tvalid};
                        wr_last = s_axis_tvalid &&
                                  (post_len == {{AW{1'b0}}, 1'b1});
                        if (wr_last) st_d = ST_DONE;
                    end
                end
            end
            ST_POST: begin
                if (!ena) begin
                    st_d = ST_IDLE;
                end else if (s_axis_tvalid) begin
                    wr    = 1'b1;
                    cnt_d = cnt_inc;
                    if (cnt_inc == post_len) begin
                        wr_last = 1'b1;
                        st_d    = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!ena) st_d = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
        if (wr) addr_d = addr_q + 1'b1;
    end

    always_comb begin
        we_d = wr;
        wa_d = wr ? addr_q : wa_q;
        wd_d = wr ? (wr_last ? last_wd : smp) : wd_q;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            st_q    <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            taddr_q <= '0;
            pre_q   <= '0;
            edge_q  <= 1'b0;
            slope_q <= 1'b0;
            chsel_q <= '0;
            thr_q   <= '0;
            wa_q    <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            st_q    <= st_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            taddr_q <= taddr_d;
            pre_q   <= pre_d;
            edge_q  <= edge_d;
            slope_q <= slope_d;
            chsel_q <= chsel_d;
            thr_q   <= thr_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
        end
    end

    assign daq_status = {16'(taddr_q), 13'd0,
                         (st_q == ST_POST) || (st_q == ST_DONE),
                         armed,
                         st_q == ST_DONE};

    assign s_axis_tready     = 1'b1;
    assign bram_porta_clk    = aclk;
    assign bram_porta_addr   = wa_q;
    assign bram_porta_wrdata = wd_q;
    assign bram_porta_we     = we_q;

endmodule

// File: tb/tb_axis_daq_mc.sv
// Randomized self-checking bench for axis_daq_mc (depth 16, 2 channels)
// against a beat-level capture model.
module tb_axis_daq_mc;
    localparam int SW    = 16;
    localparam int NCH   = 2;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int TW    = 32;
`ifdef DAQ_DELIMITER_EN
    localparam bit DELIM = 1'b1;
`else
    localparam bit DELIM = 1'b0;
`endif

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [31:0]   daq_control = '0;
    logic [15:0]   daq_pretrigger = '0;
    logic [31:0]   daq_status;
    logic          s_axis_tready;
    logic [TW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          bram_porta_clk;
    logic [AW-1:0] bram_porta_addr;
    logic [SW-1:0] bram_porta_wrdata;
    logic          bram_porta_we;

    int n_chk = 0;
    int n_err = 0;

    bit          en, md, slp;
    logic [3:0]  ch;
    logic [15:0] thr16;

    logic [31:0] beats[$];
    int          gaps[$];
    int          force_at;
    int          wq_a[$];
    int          wq_d[$];
    int          ea[$];
    int          ed[$];

    always #5 aclk = ~aclk;

    axis_daq_mc #(
        .AXIS_TDATA_WIDTH(TW),
        .SAMPLE_WIDTH    (SW),
        .NUM_CH          (NCH),
        .BRAM_ADDR_WIDTH (AW)
    ) dut (
        .aclk             (aclk),
        .areset           (areset),
        .daq_control      (daq_control),
        .daq_pretrigger   (daq_pretrigger),
        .daq_status       (daq_status),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .bram_porta_clk   (bram_porta_clk),
        .bram_porta_addr  (bram_porta_addr),
        .bram_porta_wrdata(bram_porta_wrdata),
        .bram_porta_we    (bram_porta_we)
    );

    always @(negedge aclk) begin
        if (bram_porta_we) begin
            wq_a.push_back(int'(bram_porta_addr));
            wq_d.push_back(int'(bram_porta_wrdata));
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit v, input logic [31:0] d, input bit f);
        @(negedge aclk);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        daq_control   = {thr16, 8'h00, ch, slp, md, f, en};
    endtask

    task automatic clr_stim();
        beats.delete();
        gaps.delete();
        force_at = -1;
    endtask

    task automatic add(input int d0, input int d1, input int gap);
        beats.push_back({16'(d1), 16'(d0)});
        gaps.push_back(gap);
    endtask

    // Beat-level model: beat k lands at address k mod depth; the first
    // pretrigger beats are never tested; capture ends depth-pre beats
    // after (and including) the trigger beat.
    task automatic model(input int pre, output int tix, output bit done);
        int pe, chi, plen, nw, n, thr_i;
        bit pv, pp, pass, cond;
        logic signed [15:0] s;
        logic [15:0] u;
        logic [31:0] w;
        pe    = (pre > DEPTH - 1) ? DEPTH - 1 : pre;
        chi   = (int'(ch) < NCH) ? int'(ch) : 0;
        plen  = DEPTH - pe;
        n     = beats.size();
        thr_i = int'($signed(thr16));
        tix   = -1;
        pv    = 1'b0;
        pp    = 1'b0;
        for (int k = 0; k < n; k++) begin
            w    = beats[k];
            s    = w[chi*SW +: SW];
            pass = slp ? (int'(s) <= thr_i) : (int'(s) >= thr_i);
            cond = md ? (pv && !pp && pass) : pass;
            if (tix < 0 && k >= pe) begin
                if (force_at == k) tix = k;
                else if (cond) tix = k;
            end
            pv = 1'b1;
            pp = pass;
        end
        done = (tix >= 0) && (tix + plen <= n);
        nw   = done ? tix + plen : n;
        ea.delete();
        ed.delete();
        for (int k = 0; k < nw; k++) begin
            w = beats[k];
            u = w[chi*SW +: SW];
            if (DELIM && done && k == nw - 1) u = 16'h7FFF;
            ea.push_back(k % DEPTH);
            ed.push_back(int'(u));
        end
    endtask

    task automatic run_capture(input string tag, input int pre, input bit m,
                               input bit sl, input int thr, input int c);
        int tix, n;
        bit done;
        md             = m;
        slp            = sl;
        thr16          = 16'(thr);
        ch             = 4'(c);
        daq_pretrigger = 16'(pre);
        wq_a.delete();
        wq_d.delete();
        en = 1'b1;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        for (int k = 0; k < beats.size(); k++) begin
            for (int g = 0; g < gaps[k]; g++) step(1'b0, $urandom(), 1'b0);
            if (force_at == k) step(1'b0, $urandom(), 1'b1);
            step(1'b1, beats[k], 1'b0);
        end
        repeat (4) step(1'b0, '0, 1'b0);
        model(pre, tix, done);
        n = ea.size();
        #1;
        chk({tag, ".nwr"}, wq_a.size(), n);
        for (int i = 0; i < n && i < wq_a.size(); i++) begin
            chk($sformatf("%s.a%0d", tag, i), wq_a[i], ea[i]);
            chk($sformatf("%s.d%0d", tag, i), wq_d[i], ed[i]);
        end
        chk({tag, ".done"}, daq_status[0], done);
        chk({tag, ".armed"}, daq_status[1], tix < 0);
        chk({tag, ".trig"}, daq_status[2], tix >= 0);
        if (tix >= 0) chk({tag, ".taddr"}, daq_status[31:16], tix % DEPTH);
        en = 1'b0;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        #1;
        chk({tag, ".idle"}, daq_status[2:0], 0);
    endtask

    initial begin
        int n, pre;
        en = 1'b0; md = 1'b0; slp = 1'b0; ch = '0; thr16 = '0;
        force_at = -1;
        repeat (3) @(negedge aclk);
        #1;
        chk("rst.status", daq_status, 0);
        chk("rst.we", bram_porta_we, 0);
        chk("rst.addr", bram_porta_addr, 0);
        chk("rst.data", bram_porta_wrdata, 0);
        chk("rst.tready", s_axis_tready, 1);
        @(negedge aclk);
        areset = 1'b0;

        clr_stim();
        for (int v = 96; v < 116; v++) add($urandom_range(0, 1000), v, 0);
        run_capture("lvl", 4, 1'b0, 1'b0, 100, 1);

        clr_stim();
        repeat (5) add(-60, $urandom_range(0, 500), 0);
        add(-40, 0, 0);
        add(-51, 0, 0);
        repeat (14) add(-60 - int'($urandom_range(0, 40)), 7, 0);
        run_capture("edge", 2, 1'b1, 1'b1, -50, 0);

        clr_stim();
        repeat (24) add($urandom_range(0, 100), $urandom_range(0, 100), 0);
        force_at = 7;
        run_capture("force", 3, 1'b0, 1'b0, 30000, 0);

        clr_stim();
        for (int k = 0; k < 20; k++) add(10 * k, $urandom_range(0, 999), 1);
        run_capture("tgl", 5, 1'b0, 1'b0, 50, 0);

        for (int r = 0; r < 10; r++) begin
            clr_stim();
            n = $urandom_range(30, 48);
            for (int k = 0; k < n; k++)
                add(int'($urandom_range(0, 300)) - 150,
                    int'($urandom_range(0, 300)) - 150,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
            if ($urandom_range(0, 2) == 0) force_at = $urandom_range(0, n - 1);
            case ($urandom_range(0, 4))
                0: pre = 0;
                1: pre = 20;
                2: pre = 15;
                3: pre = 3;
                default: pre = $urandom_range(1, 14);
            endcase
            run_capture($sformatf("rnd%0d", r), pre, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 200)) - 100,
                        $urandom_range(0, 3));
        end

        md = 1'b0; slp = 1'b0; ch = '0; thr16 = '0;
        daq_pretrigger = 16'd2;
        wq_a.delete();
        wq_d.delete();
        en = 1'b1;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, {16'h0, 16'hFFFB}, 1'b0);
        step(1'b1, {16'h0, 16'hFFFB}, 1'b0);
        step(1'b1, 32'd10, 1'b0);
        step(1'b1, 32'd11, 1'b0);
        step(1'b1, 32'd12, 1'b0);
        en = 1'b0;
        step(1'b1, 32'd13, 1'b0);
        @(posedge aclk);
        #1;
        chk("abort.status", daq_status[2:0], 0);
        chk("abort.we", bram_porta_we, 0);
        repeat (3) step(1'b0, '0, 1'b0);
        #1;
        chk("abort.nwr", wq_a.size(), 5);

        daq_pretrigger = 16'd3;
        en = 1'b1;
        step(1'b0, '0, 1'b0);
        for (int k = 1; k < 8; k++) step(1'b1, 32'(k * 7), 1'b0);
        @(negedge aclk);
        #2;
        areset = 1'b1;
        #1;
        chk("arst.status", daq_status, 0);
        chk("arst.we", bram_porta_we, 0);
        chk("arst.addr", bram_porta_addr, 0);
        chk("arst.data", bram_porta_wrdata, 0);
        chk("arst.tready", s_axis_tready, 1);
        en = 1'b0;
        step(1'b0, '0, 1'b0);
        areset = 1'b0;
        repeat (2) @(negedge aclk);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
